modsq_iter_ctrl: RTL and testbench
==================================

MODSQ_ITER_CTRL -- requirements
Module: modsq_iter_ctrl

Interface
REQ-001 Parameter MOD_LEN, default 1024: modulus and operand width in bits.
REQ-002 Parameter T_LEN, default 64: iteration-count width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in clk cycles per squaring.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin a run.
REQ-008 t_in  in  T_LEN  number of squarings T, sampled with start.
REQ-009 x_in  in  MOD_LEN  initial value x, sampled with start.
REQ-010 busy  out  1  high from accepted start until done.
REQ-011 done  out  1  one-cycle pulse when y_out is final.
REQ-012 y_out  out  MOD_LEN  result x^(2^T); held until the next accepted start.
REQ-013 iter_count  out  T_LEN  squarings completed in the current run.
REQ-014 sq_start_toggle  out  1  toggle-encoded start to the squaring wrapper; each edge is one start.
REQ-015 sq_in  out  MOD_LEN  operand to the squaring wrapper, registered and stable while WAIT.
REQ-016 sq_valid  in  1  one-cycle pulse, already synchronised into clk, meaning sq_out is valid.
REQ-017 sq_out  in  MOD_LEN  squaring result, sampled only when sq_valid=1.
REQ-018 error  out  1  sticky watchdog flag; exists only with MSU_ITER_TIMEOUT_EN.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and DONE, with busy=1 in ISSUE and WAIT.
REQ-020 IDLE + start + t_in!=0: latch T, set sq_in=x_in, iter_count=0, go ISSUE on the next cycle.
REQ-021 IDLE + start + t_in==0: y_out=x_in, go DONE with no toggle issued.
REQ-022 ISSUE: invert sq_start_toggle exactly once, go WAIT (toggle edge lands 1 cycle after start accepted).
REQ-023 WAIT + sq_valid: sq_in<=sq_out, y_out<=sq_out, iter_count+=1; go DONE if the new count equals T, else go ISSUE.
REQ-024 DONE: done=1 for exactly one cycle, then go IDLE.
REQ-025 start outside IDLE SHALL be ignored, with no state or register change.
REQ-026 sq_valid outside WAIT SHALL be ignored, and sq_out is not sampled.
REQ-027 iter_count SHALL never wrap; T=2^T_LEN-1 is a legal maximum and completes normally.
REQ-028 start and sq_valid in the same cycle (IDLE) SHALL accept start only.

Reset
REQ-029 reset_n=0 at any clk edge forces IDLE; busy=0, done=0, error=0, iter_count=0, y_out=0, sq_in=0, sq_start_toggle=0.
REQ-030 Reset mid-run SHALL abandon the run, and a later sq_valid in IDLE is ignored.
REQ-031 The squaring wrapper SHALL be reset concurrently with this block so that the toggle returning to 0 is not seen as a start.

Configuration
REQ-032 Macro MSU_ITER_TIMEOUT_EN defined: a cycle counter, cleared on entering WAIT, runs in WAIT.
REQ-033 If that counter reaches TIMEOUT_CYCLES without sq_valid: error<=1 (sticky until reset), go DONE, pulse done, y_out keeps its last value.
REQ-034 Macro MSU_ITER_TIMEOUT_EN undefined: no counter, no error port, and WAIT waits indefinitely.

Verification
REQ-035 Bench SHALL model the wrapper as a toggle-edge detector returning sq_out=(sq_in^2 mod N) after 7 cycles, with N=1024-bit test modulus.
REQ-036 x=3, T=4, small N=2^61-1 -> exactly 4 toggle edges, done once, y_out=3^16 mod N=43046721, iter_count=4.
REQ-037 T=0, x=0x55 -> done 1 cycle after start, y_out=0x55, sq_start_toggle unchanged.
REQ-038 Second start during run at count 2 of T=5 -> ignored; y_out=x^32 mod N; exactly 5 toggles.
REQ-039 reset_n low for 1 cycle in WAIT of T=10, then stray sq_valid -> state IDLE, iter_count=0, done never pulses.
REQ-040 With MSU_ITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, model silent -> done at 16 cycles after WAIT entry, error=1 held until reset_n=0.

Source files
------------

// File: rtl/modsq_iter_ctrl_if.sv
// Handshake bundle between the iterated-squaring controller, its requester and the squaring wrapper.
// master = requester side plus the squaring wrapper model; slave = the controller.
interface modsq_iter_ctrl_if #(
    parameter int MOD_LEN = 1024,
    parameter int T_LEN   = 64
);
    logic               start;
    logic [T_LEN-1:0]   t_in;
    logic [MOD_LEN-1:0] x_in;
    logic               busy;
    logic               done;
    logic [MOD_LEN-1:0] y_out;
    logic [T_LEN-1:0]   iter_count;
    logic               sq_start_toggle;
    logic [MOD_LEN-1:0] sq_in;
    logic               sq_valid;
    logic [MOD_LEN-1:0] sq_out;

    modport master (
        output start, t_in, x_in, sq_valid, sq_out,
        input  busy, done, y_out, iter_count, sq_start_toggle, sq_in
    );

    modport slave (
        input  start, t_in, x_in, sq_valid, sq_out,
        output busy, done, y_out, iter_count, sq_start_toggle, sq_in
    );
endinterface

// File: rtl/modsq_iter_ctrl.sv
// Iterated modular squaring controller: computes x^(2^T) by issuing T toggle-encoded squaring starts.
// Optional watchdog on each squaring enabled by defining MSU_ITER_TIMEOUT_EN (adds the error port).
module modsq_iter_ctrl #(
    parameter int MOD_LEN        = 1024,
    parameter int T_LEN          = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    modsq_iter_ctrl_if.slave  bus
`ifdef MSU_ITER_TIMEOUT_EN
    , output logic            error
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [T_LEN-1:0] t_reg;
    logic [T_LEN-1:0] next_count;

    // iter_count < t_reg holds whenever this is used, so the increment cannot wrap.
    assign next_count = bus.iter_count + T_LEN'(1);

`ifdef MSU_ITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
`endif

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and clears the datapath registers too, since y_out and sq_in have defined reset values.
        if (!reset_n) begin
            state               <= IDLE;
            t_reg               <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.y_out           <= '0;
            bus.iter_count      <= '0;
            bus.sq_start_toggle <= 1'b0;
            bus.sq_in           <= '0;
`ifdef MSU_ITER_TIMEOUT_EN
            wd_cnt              <= '0;
            error               <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.iter_count <= '0;
                        if (bus.t_in != '0) begin
                            t_reg     <= bus.t_in;
                            bus.sq_in <= bus.x_in;
                            bus.busy  <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            bus.y_out <= bus.x_in;
                            bus.done  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    bus.sq_start_toggle <= ~bus.sq_start_toggle;
                    state               <= WAIT;
`ifdef MSU_ITER_TIMEOUT_EN
                    wd_cnt              <= '0;
`endif
                end
                WAIT: begin
                    if (bus.sq_valid) begin
                        bus.sq_in      <= bus.sq_out;
                        bus.y_out      <= bus.sq_out;
                        bus.iter_count <= next_count;
                        if (next_count == t_reg) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
`ifdef MSU_ITER_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Give up on this squaring; y_out keeps the last completed value.
                        error    <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modsq_iter_ctrl.sv
// Bench for modsq_iter_ctrl: toggle-edge squaring wrapper model, spec-level run model, one compare process.
// Define MSU_ITER_TIMEOUT_EN together with the RTL to also exercise the watchdog.
module tb_modsq_iter_ctrl;

    localparam int MOD_LEN = 1024;
    localparam int T_LEN   = 4;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    modsq_iter_ctrl_if #(.MOD_LEN(MOD_LEN), .T_LEN(T_LEN)) bus ();

`ifdef MSU_ITER_TIMEOUT_EN
    logic error;
    bit   exp_err = 1'b0;
`endif

    modsq_iter_ctrl #(
        .MOD_LEN       (MOD_LEN),
        .T_LEN         (T_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
`ifdef MSU_ITER_TIMEOUT_EN
        , .error(error)
`endif
    );

    always #5 clk = ~clk;

    // Expectations written only by the stimulus process.
    logic [MOD_LEN-1:0] n_mod;
    logic [MOD_LEN-1:0] exp_y = '0;
    logic [MOD_LEN-1:0] lit_y = '0;
    int exp_count = 0, exp_togs = 0, exp_dones = 0, exp_done_cyc = 0;
    bit lit_valid = 1'b0, run_active = 1'b0, idle_after_reset = 1'b0, silent = 1'b0;
    int run_id = 0, req_idle = 0, stray_cnt = 0;

    // Owned by the compare process.
    int n_tests = 0, n_fail = 0;
    int tog_seen = 0, done_seen = 0, tog_base = 0, done_base = 0;
    int seen_run = 0, cyc = 0, ack_idle = 0;
    logic tog_prev = 1'b0;

    function automatic logic [MOD_LEN-1:0] sq_mod(input logic [MOD_LEN-1:0] a, input logic [MOD_LEN-1:0] n);
        logic [2*MOD_LEN-1:0] p;
        p = {{MOD_LEN{1'b0}}, a} * {{MOD_LEN{1'b0}}, a};
        p = p % {{MOD_LEN{1'b0}}, n};
        return p[MOD_LEN-1:0];
    endfunction

    function automatic logic [MOD_LEN-1:0] pow2t(input logic [MOD_LEN-1:0] x, input int t,
                                                  input logic [MOD_LEN-1:0] n);
        logic [MOD_LEN-1:0] y;
        y = x;
        for (int i = 0; i < t; i++) y = sq_mod(y, n);
        return y;
    endfunction

    task automatic check(input string name, input logic [MOD_LEN-1:0] act, input logic [MOD_LEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (low 128 bits)", name, act[127:0], exp[127:0]);
        end
    endtask

    // Squaring wrapper: each toggle edge captures sq_in and answers sq_in^2 mod N 7 cycles later.
    logic [MOD_LEN-1:0] w_res;
    logic w_prev = 1'b0;
    int w_cnt = 0, stray_seen = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            w_prev       = 1'b0;
            w_cnt        = 0;
            bus.sq_valid = 1'b0;
            bus.sq_out   = '0;
        end else begin
            bus.sq_valid = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen   = stray_cnt;
                bus.sq_valid = 1'b1;
                bus.sq_out   = {32{32'ha5a5_5a5a}};
            end
            if (w_cnt != 0) begin
                w_cnt--;
                if (w_cnt == 0) begin
                    bus.sq_valid = 1'b1;
                    bus.sq_out   = w_res;
                end
            end
            if (bus.sq_start_toggle != w_prev) begin
                w_prev = bus.sq_start_toggle;
                if (!silent) begin
                    w_res = sq_mod(bus.sq_in, n_mod);
                    w_cnt = 7;
                end
            end
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (run_id != seen_run) begin
            seen_run  = run_id;
            cyc       = 0;
            tog_base  = tog_seen;
            done_base = done_seen;
        end else begin
            cyc++;
        end
        if (!reset_n) begin
            tog_prev = 1'b0;
        end else begin
            if (bus.sq_start_toggle != tog_prev) begin
                tog_prev = bus.sq_start_toggle;
                tog_seen++;
            end
            if (bus.done) begin
                done_seen++;
                if (run_active) begin
                    check("done_expected", exp_dones, 1);
                    check("done_y_model", bus.y_out, exp_y);
                    check("done_count", bus.iter_count, exp_count);
                    check("done_toggles", tog_seen - tog_base, exp_togs);
                    check("done_busy_low", bus.busy, 0);
                    if (exp_done_cyc != 0) check("done_latency", cyc, exp_done_cyc);
                    if (lit_valid) check("done_y_literal", bus.y_out, lit_y);
`ifdef MSU_ITER_TIMEOUT_EN
                    check("done_error", error, exp_err);
`endif
                end
            end
            if (run_active && bus.busy) begin
                check("count_bound", bus.iter_count <= exp_count, 1);
                check("toggle_bound", (tog_seen - tog_base) <= exp_togs, 1);
            end
        end
        if (req_idle != ack_idle) begin
            ack_idle = req_idle;
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
            check("idle_count", bus.iter_count, exp_count);
            check("idle_y", bus.y_out, exp_y);
            check("idle_done_pulses", done_seen - done_base, exp_dones);
`ifdef MSU_ITER_TIMEOUT_EN
            check("idle_error", error, exp_err);
`endif
            if (idle_after_reset) begin
                check("idle_toggle", bus.sq_start_toggle, 0);
                check("idle_sq_in", bus.sq_in, 0);
            end
        end
    end

    task automatic expect_run(input logic [MOD_LEN-1:0] x, input int t, input logic [MOD_LEN-1:0] n);
        n_mod        = n;
        exp_y        = pow2t(x, t, n);
        exp_count    = t;
        exp_togs     = t;
        exp_dones    = 1;
        exp_done_cyc = (t == 0) ? 1 : 0;
        lit_valid    = 1'b0;
        run_active   = 1'b1;
    endtask

    task automatic launch(input logic [MOD_LEN-1:0] x, input int t, input bit with_stray);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.t_in  = T_LEN'(t);
        bus.x_in  = x;
        run_id++;
        if (with_stray) stray_cnt++;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_seen;
        for (int i = 0; i < budget && done_seen == base; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        run_active = 1'b0;
    endtask

    task automatic wait_count(input int c, input int budget);
        for (int i = 0; i < budget && bus.iter_count != T_LEN'(c); i++) @(negedge clk);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        req_idle++;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [MOD_LEN-1:0] n61, n_big, x_wide;
        n61        = '0;
        n61[60:0]  = '1;
        n_big      = '0;
        n_big[MOD_LEN-1] = 1'b1;
        n_big[31:0] = 32'h9e37_79b9;
        x_wide     = n_big - 17;
        n_mod      = n61;
        bus.start  = 1'b0;
        bus.t_in   = '0;
        bus.x_in   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        reset_n          = 1'b1;
        idle_after_reset = 1'b1;
        idle_check();
        idle_after_reset = 1'b0;

        // x=3, T=4, N=2^61-1.
        expect_run(3, 4, n61);
        lit_valid = 1'b1; lit_y = 43046721;
        launch(3, 4, 1'b0);
        wait_done(400);
        idle_check();

        // T=0 passes x straight through one cycle after start.
        expect_run(MOD_LEN'(32'h55), 0, n61);
        lit_valid = 1'b1; lit_y = MOD_LEN'(32'h55);
        launch(MOD_LEN'(32'h55), 0, 1'b0);
        wait_done(50);
        idle_check();

        // Second start at count 2 of T=5 is ignored.
        expect_run(3, 5, n_big);
        lit_valid = 1'b1; lit_y = MOD_LEN'(64'd1853020188851841);
        launch(3, 5, 1'b0);
        wait_count(2, 400);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.t_in = T_LEN'(1); bus.x_in = 7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(400);
        idle_check();

        // start and sq_valid together in IDLE: only the start counts.
        expect_run(5, 3, n61);
        lit_valid = 1'b1; lit_y = 390625;
        launch(5, 3, 1'b1);
        wait_done(400);
        idle_check();

        // Largest T the counter can hold.
        expect_run(3, 15, n61);
        launch(3, 15, 1'b0);
        wait_done(600);
        idle_check();

        // Wide operand against the 1024-bit modulus.
        expect_run(x_wide, 3, n_big);
        launch(x_wide, 3, 1'b0);
        wait_done(400);
        idle_check();

        // Reset during WAIT of T=10, then a stray sq_valid.
        expect_run(5, 10, n_big);
        launch(5, 10, 1'b0);
        wait_count(3, 400);
        @(posedge clk); #1;
        run_active = 1'b0;
        reset_n    = 1'b0;
        @(posedge clk); #1;
        reset_n    = 1'b1;
        stray_cnt++;
        repeat (20) @(negedge clk);
        exp_count = 0; exp_y = '0; exp_dones = 0;
        idle_after_reset = 1'b1;
        idle_check();
        idle_after_reset = 1'b0;

`ifdef MSU_ITER_TIMEOUT_EN
        // Silent wrapper: watchdog ends the run 16 cycles into WAIT.
        expect_run(3, 2, n61);
        launch(3, 2, 1'b0);
        wait_done(400);
        idle_check();
        silent       = 1'b1;
        exp_count    = 0;
        exp_togs     = 1;
        exp_dones    = 1;
        exp_done_cyc = 1 + TMO;
        exp_err      = 1'b1;
        run_active   = 1'b1;
        launch(9, 2, 1'b0);
        wait_done(200);
        repeat (10) @(negedge clk);
        idle_check();
        pulse_reset(1);
        exp_err = 1'b0; exp_y = '0; exp_count = 0;
        idle_check();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
